// File: rtl/demux1to4_32_hs.sv
// Registered 1-to-4 demultiplexer with a valid/ready handshake on the source side and on each channel.
// Define DEMUX_CNT_EN to add per-channel transfer counters, which are exposed on xfer_cnt.
module demux1to4_32_hs #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic             d0_valid,
  output logic             d1_valid,
  output logic             d2_valid,
  output logic             d3_valid,
  input  logic             d0_ready,
  input  logic             d1_ready,
  input  logic             d2_ready,
  input  logic             d3_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [4*CNT_W-1:0] xfer_cnt
`endif
);

  // state   | meaning
  // S_EMPTY | channel holds no undelivered word
  // S_FULL  | channel holds a word awaiting its consumer
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       state_q [4];
  logic [0:0]       state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [3:0]       full;
  logic [3:0]       rdy;
  logic             accept;

  assign rdy = {d3_ready, d2_ready, d1_ready, d0_ready};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      full[i] = (state_q[i] == S_FULL);
    end
  end

  // A full channel can take a new word in the same cycle that its consumer drains it.
  assign in_ready = ~full[select] | rdy[select];
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      if (accept && (select == 2'(i))) begin
        state_d[i] = S_FULL;
        data_d[i]  = din;
      end else if (full[i] && rdy[i]) begin
        state_d[i] = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= S_EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  assign d0 = data_q[0];
  assign d1 = data_q[1];
  assign d2 = data_q[2];
  assign d3 = data_q[3];

  assign d0_valid = full[0];
  assign d1_valid = full[1];
  assign d2_valid = full[2];
  assign d3_valid = full[3];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // The counters wrap naturally at 2^CNT_W.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept && (select == 2'(i))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign xfer_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  // CNT_W only sizes the counters; this keeps the parameter referenced when the counters are left out.
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_demux1to4_32_hs.sv
// Scoreboard bench for demux1to4_32_hs: expected words are queued per channel when a word is accepted.
// A monitor pops and compares each word when the DUT delivers it. Define DEMUX_CNT_EN to check the counters.
module tb_demux1to4_32_hs;
  localparam int WIDTH = 32;
`ifdef DEMUX_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d_a [4];
  logic [3:0]       dv;
  logic [3:0]       dr;
`ifdef DEMUX_CNT_EN
  logic [4*CNT_W-1:0] xfer_cnt;
  int unsigned        cnt_m [4];
`endif

  logic [WIDTH-1:0] exp_q [4][$];
  logic [WIDTH-1:0] last_val [4];
  int               n_chk = 0;
  int               n_fail = 0;
  int               acc;

  always #5 clk = ~clk;

  demux1to4_32_hs #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .select(sel), .in_valid(in_valid), .in_ready(in_ready),
    .d0(d_a[0]), .d1(d_a[1]), .d2(d_a[2]), .d3(d_a[3]),
    .d0_valid(dv[0]), .d1_valid(dv[1]), .d2_valid(dv[2]), .d3_valid(dv[3]),
    .d0_ready(dr[0]), .d1_ready(dr[1]), .d2_ready(dr[2]), .d3_ready(dr[3])
`ifdef DEMUX_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      exp_q[c].delete();
      last_val[c] = '0;
`ifdef DEMUX_CNT_EN
      cnt_m[c] = 0;
`endif
    end
  endtask

  // Monitor: compares every channel against the scoreboard and pops a word when it is delivered.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'((exp_q[sel].size() == 0) || dr[sel]));
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("d%0d_valid", c), 64'(dv[c]), 64'(exp_q[c].size() != 0));
        if (exp_q[c].size() != 0) begin
          chk($sformatf("d%0d_data", c), 64'(d_a[c]), 64'(exp_q[c][0]));
          if (dr[c]) last_val[c] = exp_q[c].pop_front();
        end else begin
          chk($sformatf("d%0d_hold", c), 64'(d_a[c]), 64'(last_val[c]));
        end
`ifdef DEMUX_CNT_EN
        chk($sformatf("cnt%0d", c), 64'(xfer_cnt[c*CNT_W +: CNT_W]), 64'(cnt_m[c]));
`endif
      end
    end
  end

  // Reference model: a word is accepted when its channel's queue is empty or being drained.
  always @(negedge clk) begin
    #1;
    if (rst_n && in_valid && ((exp_q[sel].size() == 0) || dr[sel])) begin
      exp_q[sel].push_back(din);
`ifdef DEMUX_CNT_EN
      cnt_m[sel] = (cnt_m[sel] + 1) % (1 << CNT_W);
`endif
    end
  end

  initial begin
    rst_n = 1'b0; din = '0; sel = '0; in_valid = 1'b0; dr = '0;
    clear_model();
    #2;
    chk("reset_valid", 64'(dv), 64'h0);
    for (int c = 0; c < 4; c++) chk($sformatf("reset_d%0d", c), 64'(d_a[c]), 64'h0);
    #10 rst_n = 1'b1;
    cyc();

    // A single word to channel 2.
    din = 32'hDEADBEEF; sel = 2'd2; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t2_d2", 64'(d_a[2]), 64'hDEADBEEF);
    chk("t2_valid", 64'(dv), 64'b0100);

    // Channel 1 stalled by its consumer, then released.
    din = 32'h1111_0001; sel = 2'd1; in_valid = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      din = $urandom;
      #1;
      chk("t3_stall_ready", 64'(in_ready), 64'h0);
      chk("t3_stall_d1", 64'(d_a[1]), 64'h1111_0001);
      cyc();
    end
    dr[1] = 1'b1; din = 32'h2222_0002;
    #1;
    chk("t3_release_ready", 64'(in_ready), 64'h1);
    cyc();
    chk("t3_d1_new", 64'(d_a[1]), 64'h2222_0002);
    chk("t3_d1_valid", 64'(dv[1]), 64'h1);
    in_valid = 1'b0; dr = '0;

    // A stalled channel 1 does not block channel 3.
    din = 32'h3333_0003; sel = 2'd3; in_valid = 1'b1;
    #1;
    chk("t4_ready", 64'(in_ready), 64'h1);
    cyc();
    chk("t4_d3", 64'(d_a[3]), 64'h3333_0003);
    chk("t4_d1", 64'(d_a[1]), 64'h2222_0002);
    in_valid = 1'b0;

    // Eight back-to-back words into channel 0.
    acc = 0; sel = 2'd0; dr[0] = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din = $urandom;
      #1;
      if (in_ready) acc++;
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    dr = '0;
    chk("t5_accepts", 64'(acc), 64'd8);

    // Reset between clock edges while channels are full.
    for (int c = 0; c < 4; c++) begin
      sel = 2'(c); din = $urandom; in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 64'(dv), 64'h0);
    for (int c = 0; c < 4; c++) chk($sformatf("t1_d%0d", c), 64'(d_a[c]), 64'h0);
    clear_model();
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc();

`ifdef DEMUX_CNT_EN
    // Seventeen words into channel 2 make its counter wrap.
    dr = 4'hF; sel = 2'd2; in_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      din = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("t6_cnt2", 64'(xfer_cnt[2*CNT_W +: CNT_W]), 64'd1);
    chk("t6_cnt_others", 64'({xfer_cnt[3*CNT_W +: CNT_W], xfer_cnt[1*CNT_W +: CNT_W], xfer_cnt[0 +: CNT_W]}), 64'd0);
    dr = '0;
`endif

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      din = $urandom;
      sel = 2'($urandom_range(3));
      in_valid = ($urandom_range(3) != 0);
      dr = 4'($urandom_range(15));
      cyc();
    end
    in_valid = 1'b0; dr = 4'hF;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
